// File: rtl/vga_pkg.sv
// Shared timing defaults, counter widths and pixel type for the VGA timing block.
package vga_pkg;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;

    localparam int DEF_VDISP  = 480;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;

    localparam int HW = 11;
    localparam int VW = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '0;
    localparam rgb_t RGB_WHITE = '1;

endpackage

// File: rtl/vga_test_pattern.sv
// Grid generator: white on every 32nd column/line inside the active area.
module vga_test_pattern
    import vga_pkg::*;
(
    input  logic [HW-1:0] hcnt,
    input  logic [VW-1:0] vcnt,
    input  logic          active,
    output rgb_t          rgb
);

    logic on_grid;

    always_comb begin
        on_grid = (hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0);
        rgb     = RGB_BLACK;
        if (active && on_grid) begin
            rgb = RGB_WHITE;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing with FIFO-fed pixels; define VGA_TEST_PATTERN_EN
// to replace the FIFO path with an internal grid pattern.
module vga_timing
    import vga_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VDISP  = DEF_VDISP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP
)
(
    input  logic          pixel_clk,
    input  logic          pixel_rst_n,
    input  logic [23:0]   pix_data,
    input  logic          pix_empty,
    output logic          pix_rd,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK,
    output logic          VGA_SYNC,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic [HW-1:0] pix_x,
    output logic [VW-1:0] pix_y,
    output logic          frame_start,
    output logic          underrun
);

    localparam int HTOT = HDISP + HFP + HPULSE + HBP;
    localparam int VTOT = VDISP + VFP + VPULSE + VBP;

    localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(HDISP);
    localparam logic [HW-1:0] HS_ON  = HW'(HDISP + HFP);
    localparam logic [HW-1:0] HS_OFF = HW'(HDISP + HFP + HPULSE);

    localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(VDISP);
    localparam logic [VW-1:0] VS_ON  = VW'(VDISP + VFP);
    localparam logic [VW-1:0] VS_OFF = VW'(VDISP + VFP + VPULSE);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          hlast;
    logic          vlast;
    logic          active;
    logic          hs_n;
    logic          vs_n;
    logic          origin;
    rgb_t          pix_rgb;

    always_comb begin
        hlast  = (hcnt == H_LAST);
        vlast  = (vcnt == V_LAST);
        active = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_n   = !((hcnt >= HS_ON) && (hcnt < HS_OFF));
        vs_n   = !((vcnt >= VS_ON) && (vcnt < VS_OFF));
        origin = (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hlast) begin
            hcnt <= '0;
            vcnt <= vlast ? '0 : vcnt + VW'(1);
        end else begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Timing outputs trail the counters by one cycle.
    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            VGA_HS      <= hs_n;
            VGA_VS      <= vs_n;
            VGA_BLANK   <= active;
            pix_x       <= hcnt;
            pix_y       <= vcnt;
            frame_start <= origin;
        end
    end

`ifdef VGA_TEST_PATTERN_EN

    rgb_t grid;
    rgb_t rgb_q;
    logic unused_fifo;

    assign unused_fifo = ^{pix_data, pix_empty};

    vga_test_pattern u_pattern (
        .hcnt   (hcnt),
        .vcnt   (vcnt),
        .active (active),
        .rgb    (grid)
    );

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            rgb_q <= RGB_BLACK;
        end else begin
            rgb_q <= grid;
        end
    end

    assign pix_rd   = 1'b0;
    assign underrun = 1'b0;
    assign pix_rgb  = rgb_q;

`else

    logic rd_q;
    logic under_q;

    assign pix_rd = pixel_rst_n & active & ~pix_empty;

    // rd_q marks the output cycle whose pixel the FIFO is presenting now.
    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            rd_q    <= 1'b0;
            under_q <= 1'b0;
        end else begin
            rd_q    <= pix_rd;
            under_q <= under_q | (active & pix_empty);
        end
    end

    assign underrun = under_q;
    assign pix_rgb  = rd_q ? rgb_t'(pix_data) : RGB_BLACK;

`endif

    assign VGA_R    = pix_rgb.r;
    assign VGA_G    = pix_rgb.g;
    assign VGA_B    = pix_rgb.b;
    assign VGA_SYNC = 1'b0;

endmodule
